mem_responder: RTL and testbench

- Memory-side endpoint of the CPU memory bus: accepts mreq transactions on a decoupled input and returns one mtrans response per request on a decoupled output, strictly in order.
- Backed by an internal word-addressed RAM; fixed, parameterised access latency; response buffering sized by credit.
- Serves as boot/instruction/data memory behind the mem_arbiter slave port, and as the bench-side memory model for cpu.

---
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - Word-addressed RAM endpoint for the CPU memory bus with fixed latency and credit-sized response buffer
//
// Purpose:
//   Accepts mreq transactions, performs the RAM access at the fire edge,
//   carries the result through a fixed LATENCY-stage delay line and queues it
//   in a RESP_DEPTH-entry response FIFO. Responses leave strictly in order.
//   The request side is throttled by a credit count covering both the delay
//   line and the FIFO, so the FIFO can never overflow.
//
// Ports:
//   clk               in   clock
//   rst               in   asynchronous active-high reset (RAM contents kept)
//   i_mem_req_valid   in   request valid
//   o_mem_req_ready   out  request ready (registered credit compare)
//   i_mem_req_addr    in   byte address, [1:0] ignored
//   i_mem_req_we      in   1 = write, 0 = read
//   i_mem_req_be      in   byte-lane enables for writes
//   i_mem_req_wdata   in   write data
//   o_mem_resp_valid  out  response FIFO non-empty
//   i_mem_resp_ready  in   response consumer ready
//   o_mem_resp_data   out  FIFO head word (read data or merged post-write word)

module mem_responder #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH      = 1024,
  parameter int          LATENCY    = 2,
  parameter int          RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_req_valid,
  output logic        o_mem_req_ready,
  input  logic [31:0] i_mem_req_addr,
  input  logic        i_mem_req_we,
  input  logic [3:0]  i_mem_req_be,
  input  logic [31:0] i_mem_req_wdata,
  output logic        o_mem_resp_valid,
  input  logic        i_mem_resp_ready,
  output logic [31:0] o_mem_resp_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  // Storage
  logic [31:0]         r_ram [DEPTH];
  logic [LATENCY-1:0]  r_dl_valid;
  logic [31:0]         r_dl_data [LATENCY];
  logic [31:0]         r_buf [RESP_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_buf_cnt;
  logic [CW-1:0]       r_cnt;

  logic                w_req_fire;
  logic                w_resp_fire;
  logic                w_push;
  logic                w_buf_full;
  logic [AW-1:0]       w_idx;
  logic [31:0]         w_rd_word;
  logic [31:0]         w_merged;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on the registered credit count. A request presented
  // while rst is high must not fire, even though ready reads 1 in reset.
  assign o_mem_req_ready  = (r_cnt < CW'(RESP_DEPTH));
  assign w_req_fire       = i_mem_req_valid && o_mem_req_ready && !rst;

  assign o_mem_resp_valid = (r_buf_cnt != '0);
  assign o_mem_resp_data  = r_buf[r_rd_ptr];
  assign w_resp_fire      = o_mem_resp_valid && i_mem_resp_ready;

  assign w_push     = r_dl_valid[LATENCY-1];
  assign w_buf_full = (r_buf_cnt == CW'(RESP_DEPTH));

  // Out-of-window addresses simply wrap: the cast keeps the low index bits.
  assign w_idx     = AW'((i_mem_req_addr - BASE) >> 2);
  assign w_rd_word = r_ram[w_idx];

  // For a read (or disabled lanes) the merge returns the stored word, so the
  // same value serves as both the RAM write data and the response data.
  always_comb begin
    w_merged = w_rd_word;
    for (int i = 0; i < 4; i++) begin
      if (i_mem_req_we && i_mem_req_be[i]) begin
        w_merged[8*i +: 8] = i_mem_req_wdata[8*i +: 8];
      end
    end
  end

  // RAM is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_req_fire && i_mem_req_we) begin
      r_ram[w_idx] <= w_merged;
    end
  end

  // Delay line: never stalls; credits guarantee room in the FIFO on arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid[0] <= w_req_fire;
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_dl_data[0] <= w_merged;
    for (int i = 1; i < LATENCY; i++) begin
      r_dl_data[i] <= r_dl_data[i-1];
    end
  end

  // Response FIFO payload (registered head, not fall-through).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= r_dl_data[LATENCY-1];
    end
  end

  // FIFO pointers, occupancy and credit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_buf_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_resp_fire) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end

      case ({w_push, w_resp_fire})
        2'b10:   r_buf_cnt <= r_buf_cnt + CW'(1);
        2'b01:   r_buf_cnt <= r_buf_cnt - CW'(1);
        default: r_buf_cnt <= r_buf_cnt;
      endcase

      case ({w_req_fire, w_resp_fire})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // The credit rule makes this unreachable; hitting it means broken credits.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_buf_full && !w_resp_fire))
    else $error("mem_responder: response buffer overflow");

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - Directed self-checking bench for mem_responder

module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        i_mem_req_valid;
  logic        o_mem_req_ready;
  logic [31:0] i_mem_req_addr;
  logic        i_mem_req_we;
  logic [3:0]  i_mem_req_be;
  logic [31:0] i_mem_req_wdata;
  logic        o_mem_resp_valid;
  logic        i_mem_resp_ready;
  logic [31:0] o_mem_resp_data;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] q_data[$];
  int          q_cyc[$];

  mem_responder #(
    .BASE(BASE), .DEPTH(1024), .LATENCY(2), .RESP_DEPTH(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_mem_req_valid  (i_mem_req_valid),
    .o_mem_req_ready  (o_mem_req_ready),
    .i_mem_req_addr   (i_mem_req_addr),
    .i_mem_req_we     (i_mem_req_we),
    .i_mem_req_be     (i_mem_req_be),
    .i_mem_req_wdata  (i_mem_req_wdata),
    .o_mem_resp_valid (o_mem_resp_valid),
    .i_mem_resp_ready (i_mem_resp_ready),
    .o_mem_resp_data  (o_mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Response monitor: inputs change at posedge+1, so negedge is stable.
  always @(negedge clk) begin
    if (!rst && o_mem_resp_valid && i_mem_resp_ready) begin
      q_data.push_back(o_mem_resp_data);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_q();
    q_data.delete();
    q_cyc.delete();
  endtask

  // One request; returns with valid low so consecutive calls are back-to-back.
  task automatic send(input logic [31:0] addr, input logic we,
                      input logic [3:0] be, input logic [31:0] wdata);
    int n;
    i_mem_req_valid = 1'b1;
    i_mem_req_addr  = addr;
    i_mem_req_we    = we;
    i_mem_req_be    = be;
    i_mem_req_wdata = wdata;
    n = 0;
    while (!o_mem_req_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("req_wait_timeout", 32'(n), 32'd0);
    step();
    i_mem_req_valid = 1'b0;
  endtask

  logic [31:0] exp3 [8];
  logic [31:0] exp4 [4];
  int          n_fired;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    i_mem_req_valid  = 1'b0;
    i_mem_req_addr   = '0;
    i_mem_req_we     = 1'b0;
    i_mem_req_be     = '0;
    i_mem_req_wdata  = '0;
    i_mem_resp_ready = 1'b1;

    // Reset state
    #1;
    check("rst_resp_valid", 32'(o_mem_resp_valid), 32'd0);
    check("rst_req_ready",  32'(o_mem_req_ready),  32'd1);
    idle(2);
    rst = 1'b0;
    idle(1);

    // T1: latency of a single read
    send(BASE, 1'b1, 4'hF, 32'hDEAD_BEEF);
    idle(6);
    clear_q();
    i_mem_req_valid = 1'b1;
    i_mem_req_addr  = BASE;
    i_mem_req_we    = 1'b0;
    check("t1_ready", 32'(o_mem_req_ready), 32'd1);
    step();
    i_mem_req_valid = 1'b0;
    check("t1_valid_c1", 32'(o_mem_resp_valid), 32'd0);
    step();
    check("t1_valid_c2", 32'(o_mem_resp_valid), 32'd0);
    step();
    check("t1_valid_c3", 32'(o_mem_resp_valid), 32'd1);
    check("t1_data", o_mem_resp_data, 32'hDEAD_BEEF);
    idle(4);

    // T2: partial write then back-to-back read
    send(BASE + 32'd4, 1'b1, 4'hF, 32'hAABB_CCDD);
    idle(6);
    clear_q();
    send(BASE + 32'd4, 1'b1, 4'b0101, 32'h1122_3344);
    send(BASE + 32'd4, 1'b0, 4'h0, 32'h0);
    idle(6);
    check("t2_count", 32'(q_data.size()), 32'd2);
    if (q_data.size() >= 2) begin
      check("t2_wr_resp", q_data[0], 32'hAA22_CC44);
      check("t2_rd_resp", q_data[1], 32'hAA22_CC44);
    end

    // T3: 8 back-to-back reads at full throughput
    exp3[0] = 32'hDEAD_BEEF;
    exp3[1] = 32'hAA22_CC44;
    for (int i = 2; i < 8; i++) begin
      exp3[i] = 32'h1111_1111 * 32'(i);
      send(BASE + 32'(4 * i), 1'b1, 4'hF, exp3[i]);
    end
    idle(6);
    clear_q();
    for (int i = 0; i < 8; i++) begin
      i_mem_req_valid = 1'b1;
      i_mem_req_addr  = BASE + 32'(4 * i);
      i_mem_req_we    = 1'b0;
      check($sformatf("t3_ready_%0d", i), 32'(o_mem_req_ready), 32'd1);
      step();
    end
    i_mem_req_valid = 1'b0;
    idle(6);
    check("t3_count", 32'(q_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (q_data.size() > i) begin
        check($sformatf("t3_data_%0d", i), q_data[i], exp3[i]);
        if (i > 0) check($sformatf("t3_cycle_%0d", i), 32'(q_cyc[i] - q_cyc[0]), 32'(i));
      end
    end

    // T4: backpressure, credit limit, head stability, drain
    exp4[0] = 32'hDEAD_BEEF;
    exp4[1] = 32'hAA22_CC44;
    exp4[2] = 32'h2222_2222;
    exp4[3] = 32'h3333_3333;
    clear_q();
    i_mem_resp_ready = 1'b0;
    n_fired = 0;
    for (int c = 0; c < 6; c++) begin
      i_mem_req_valid = 1'b1;
      i_mem_req_addr  = BASE + 32'(4 * n_fired);
      i_mem_req_we    = 1'b0;
      if (o_mem_req_ready) n_fired++;
      step();
    end
    i_mem_req_valid = 1'b0;
    check("t4_fired", 32'(n_fired), 32'd4);
    check("t4_req_ready_low", 32'(o_mem_req_ready), 32'd0);
    idle(3);
    check("t4_resp_valid", 32'(o_mem_resp_valid), 32'd1);
    check("t4_head", o_mem_resp_data, 32'hDEAD_BEEF);
    idle(2);
    check("t4_head_hold", o_mem_resp_data, 32'hDEAD_BEEF);
    i_mem_resp_ready = 1'b1;
    check("t4_ready_pre_drain", 32'(o_mem_req_ready), 32'd0);
    step();
    check("t4_ready_post_drain", 32'(o_mem_req_ready), 32'd1);
    idle(6);
    check("t4_count", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (q_data.size() > i) check($sformatf("t4_data_%0d", i), q_data[i], exp4[i]);
    end

    // T5: address aliasing and ignored low bits
    clear_q();
    send(BASE + 32'h1000, 1'b1, 4'hF, 32'h5A5A_5A5A);
    send(BASE,            1'b0, 4'h0, 32'h0);
    send(BASE + 32'd3,    1'b0, 4'h0, 32'h0);
    idle(6);
    check("t5_count", 32'(q_data.size()), 32'd3);
    if (q_data.size() >= 3) begin
      check("t5_wr_resp",  q_data[0], 32'h5A5A_5A5A);
      check("t5_alias",    q_data[1], 32'h5A5A_5A5A);
      check("t5_low_bits", q_data[2], 32'h5A5A_5A5A);
    end

    // T6: reset with outstanding responses
    send(BASE + 32'd36, 1'b1, 4'hF, 32'hCAFE_F00D);
    idle(6);
    i_mem_resp_ready = 1'b0;
    send(BASE,          1'b0, 4'h0, 32'h0);
    send(BASE + 32'd4,  1'b0, 4'h0, 32'h0);
    send(BASE + 32'd8,  1'b0, 4'h0, 32'h0);
    idle(3);
    check("t6_pre_valid", 32'(o_mem_resp_valid), 32'd1);
    rst = 1'b1;
    i_mem_req_valid = 1'b1;
    i_mem_req_addr  = BASE + 32'd36;
    i_mem_req_we    = 1'b0;
    #1;
    check("t6_rst_valid", 32'(o_mem_resp_valid), 32'd0);
    check("t6_rst_ready", 32'(o_mem_req_ready), 32'd1);
    clear_q();
    i_mem_resp_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    step();
    i_mem_req_valid = 1'b0;
    idle(6);
    check("t6_count", 32'(q_data.size()), 32'd1);
    if (q_data.size() >= 1) check("t6_data", q_data[0], 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
